// File: rtl/exc_arbiter_pkg.sv
// Shared constants and types for the pipeline exception/interrupt arbiter.
package exc_arbiter_pkg;
  localparam logic [1:0] EXC_INT    = 2'd0;
  localparam logic [1:0] EXC_SYS    = 2'd1;
  localparam logic [1:0] EXC_UNIMPL = 2'd2;
  localparam logic [1:0] EXC_OV     = 2'd3;

  // Flush masks: owning stage plus every younger stage (bit0 = F).
  localparam logic [3:0] FLUSH_OV     = 4'b1111;
  localparam logic [3:0] FLUSH_UNIMPL = 4'b0111;
  localparam logic [3:0] FLUSH_SYS    = 4'b0011;
  localparam logic [3:0] FLUSH_INT    = 4'b0001;
  localparam logic [3:0] FLUSH_RET    = 4'b0111;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_t;
endpackage

// File: rtl/exc_arbiter_int_sync.sv
// Interrupt request synchroniser, rising-edge detector and sticky pending flag.
module exc_arbiter_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic int_req_i,
  input  logic accept_i,
  output logic pending_o
);
  logic r_sync1, r_sync2, r_prev, r_pending;
  logic w_edge;

  assign w_edge = r_sync2 & ~r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_prev    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_sync1   <= int_req_i;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      // A fresh edge wins over a same-cycle accept so no request is lost.
      r_pending <= w_edge | (r_pending & ~accept_i);
    end
  end

  assign pending_o = r_pending;
endmodule

// File: rtl/exc_arbiter.sv
// Picks one exception/interrupt/eret per cycle, drives Coprocessor 0 strobes,
// pipeline flush and PC redirect, then drains flushed slots for a few cycles.
module exc_arbiter
  import exc_arbiter_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req_i,
  input  logic        sys_d_i,
  input  logic        unimpl_e_i,
  input  logic        ov_m_i,
  input  logic        ret_m_i,
  input  logic        stall_i,
  input  logic [31:0] pcf_i,
  input  logic [31:0] pcd_i,
  input  logic [31:0] pce_i,
  input  logic [31:0] pcm_i,
  input  logic [31:0] status_i,
  input  logic [31:0] epc_i,
  output logic        cause_epc_write_o,
  output logic [31:0] exc_code_o,
  output logic [31:0] epc_o,
  output logic        ret_op_o,
  output logic [3:0]  flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        int_pending_o
);
  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_pend, w_int_acc, w_take, w_ret, w_redir;
  logic [1:0]    w_code;
  logic [31:0]   w_epc, w_rpc;
  logic [3:0]    w_flush;
  logic          w_unused_status;

  assign w_unused_status = ^status_i[31:4];

  exc_arbiter_int_sync u_int_sync (
    .clk       (clk),
    .rst       (rst),
    .int_req_i (int_req_i),
    .accept_i  (w_int_acc),
    .pending_o (w_pend)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_ret       = 1'b0;
    w_int_acc   = 1'b0;
    w_code      = EXC_INT;
    w_epc       = '0;
    w_flush     = '0;
    w_rpc       = HANDLER_ADDR;
    case (r_state)
      ST_IDLE: begin
        if (!stall_i) begin
          if (ov_m_i && status_i[EXC_OV]) begin
            w_take = 1'b1; w_code = EXC_OV; w_epc = pcm_i; w_flush = FLUSH_OV;
          end else if (unimpl_e_i && status_i[EXC_UNIMPL]) begin
            w_take = 1'b1; w_code = EXC_UNIMPL; w_epc = pce_i; w_flush = FLUSH_UNIMPL;
          end else if (sys_d_i && status_i[EXC_SYS]) begin
            w_take = 1'b1; w_code = EXC_SYS; w_epc = pcd_i; w_flush = FLUSH_SYS;
          end else if (w_pend && status_i[EXC_INT]) begin
            w_take = 1'b1; w_code = EXC_INT; w_epc = pcf_i; w_flush = FLUSH_INT;
            w_int_acc = 1'b1;
          end else if (ret_m_i) begin
            w_ret = 1'b1; w_rpc = epc_i; w_flush = FLUSH_RET;
          end
        end
        if (w_take || w_ret) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Outputs exist only in the accept cycle and are held low through reset.
  assign w_redir           = (w_take | w_ret) & ~rst;
  assign cause_epc_write_o = w_take & ~rst;
  assign ret_op_o          = w_ret & ~rst;
  assign exc_code_o        = cause_epc_write_o ? {30'b0, w_code} : 32'b0;
  assign epc_o             = cause_epc_write_o ? w_epc : 32'b0;
  assign flush_o           = w_redir ? w_flush : 4'b0;
  assign redirect_o        = w_redir;
  assign redirect_pc_o     = w_redir ? w_rpc : 32'b0;
  assign int_pending_o     = w_pend & ~rst;
endmodule
